mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory-bus arbiter that sits between the Processor and the SoC's memory decode (ROMs, RAM8k, VideoRAM, keyboard, colour register). It shares the single memory bus between the CPU and a secondary bus master (DMA/loader port, e.g. VRAM fill or serial loader). Each access is sequenced against the synchronous one-cycle read latency of the memories. The CPU has priority, subject to a bounded-streak fairness rule; DMA writes into ROM space are blocked.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 8: data width.
- `MAX_CPU_STREAK`, 4: maximum consecutive CPU grants while DMA is waiting (≥1).
- `ROM_TOP`, 16'h2000: DMA writes with address < `ROM_TOP` are suppressed.
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `cpuReq` in 1: CPU request; held with its fields until `cpuAck`.
- `cpuWrite` in 1: 1 = write, 0 = read.
- `cpuAddr` in ADDR_W: CPU address.
- `cpuWdata` in DATA_W: CPU write data.
- `cpuAck` out 1: one-cycle completion pulse.
- `cpuRdata` out DATA_W: read data; valid in the `cpuAck` cycle, then held.
- `dmaReq`, `dmaWrite`, `dmaAddr`, `dmaWdata`, `dmaAck`, `dmaRdata`: same as the CPU port, for the DMA port.
- `dmaFault` out 1: one-cycle pulse coincident with `dmaAck` when a DMA write was suppressed.
- `memAddr` out ADDR_W, `memDataWrite` out DATA_W, `memWrite` out 1, `memStrobe` out 1: registered bus drive to the memory decode.
- `memDataRead` in DATA_W: decoded read data, valid the cycle after `memStrobe`.

## Operation
- FSM states:
  - IDLE → ACCESS when any request is granted.
  - ACCESS → COMPLETE unconditionally.
  - COMPLETE → IDLE unconditionally.
- Three cycles per access; no back-to-back pipelining.
- Grant is evaluated in IDLE only:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requesting: grant CPU unless `streak == MAX_CPU_STREAK`, in which case grant DMA.
- `streak` counter:
  - Increments on each CPU grant made while `dmaReq` = 1, saturating at `MAX_CPU_STREAK`.
  - Clears on any DMA grant.
  - Clears in any IDLE cycle with `dmaReq` = 0.
- On grant, owner, address, write flag and data are latched into the `mem*` registers. `memStrobe` = 1 for exactly the ACCESS cycle.
- `memWrite` = owner write flag, except DMA write with `addr < ROM_TOP`: then `memWrite` = 0 and the access still completes.
- COMPLETE:
  - Reads capture `memDataRead` into the owner's rdata register.
  - The owner's ack pulses. `dmaFault` pulses if the access was suppressed.
  - The non-owner's rdata is unchanged.
- `memAddr` and `memDataWrite` hold their last value outside ACCESS; `memWrite` = 0 outside ACCESS.
- A request dropped mid-access is a protocol violation: the access still completes and the ack still pulses.

## Timing
- Reset (async assert, sync release): state IDLE, `streak` 0. All outputs 0: `mem*`, acks, `dmaFault`, rdata.
- Reset asserted mid-access: strobe drops immediately and no ack is issued.
- Latency: request high in IDLE at cycle k → `memStrobe` at k+1 → ack and data at k+2 → IDLE at k+3.
- Earliest re-grant is at k+3. The acked requester must drop or renew its request by k+3; a request still high at k+3 is treated as a new access.
- Simultaneous requests when `streak` is saturated: DMA wins, `streak` → 0.
- Arithmetic: `streak` is `$clog2(MAX_CPU_STREAK+1)` bits, unsigned, never wraps.

## Structure
- Package `mem_arbiter_pkg`:
  - State enum (IDLE/ACCESS/COMPLETE).
  - Owner enum (CPU/DMA).
  - Default `ROM_TOP`.
- One sub-module, `mem_arbiter_grant`: combinational priority logic plus the registered `streak` counter. Outputs grant-valid and grant-owner.
- The FSM, bus registers and rdata capture stay in the top level.

## Test plan
- CPU read of 16'h0005 with `memDataRead` = 8'hA5 at k+2 → `memStrobe` at k+1, `cpuAck` and `cpuRdata` = 8'hA5 at k+2; `dmaRdata` stays 0.
- CPU and DMA both held high with `MAX_CPU_STREAK` = 4 → grant order CPU, CPU, CPU, CPU, DMA, CPU…; never 5 CPU grants in a row.
- DMA write of 8'h3C to 16'h1000 → `memStrobe` = 1 and `memWrite` = 0 at k+1; `dmaAck` and `dmaFault` at k+2.
- DMA write to 16'h4000 → `memWrite` = 1 and `dmaFault` = 0.
- Reset pulsed low during ACCESS → `memStrobe` = 0 immediately, no ack, all outputs 0; after release, the first pending request completes normally.
- DMA only, held continuously for 3 accesses → a strobe every 3 cycles, `streak` stays 0, each `dmaAck` matches its own latched address.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and defaults for the two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Access sequencer states: one grant cycle, one strobe cycle, one ack cycle.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  // Current bus owner.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // Everything below this address is ROM and must not be written by DMA.
  localparam logic [15:0] DEFAULT_ROM_TOP = 16'h2000;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : CPU, DMA and memory-decode bus bundle of the arbiter.
//               'master' is the requester/memory side, 'slave' the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  // CPU port
  logic              cpuReq;
  logic              cpuWrite;
  logic [ADDR_W-1:0] cpuAddr;
  logic [DATA_W-1:0] cpuWdata;
  logic              cpuAck;
  logic [DATA_W-1:0] cpuRdata;
  // DMA / loader port
  logic              dmaReq;
  logic              dmaWrite;
  logic [ADDR_W-1:0] dmaAddr;
  logic [DATA_W-1:0] dmaWdata;
  logic              dmaAck;
  logic [DATA_W-1:0] dmaRdata;
  logic              dmaFault;
  // Memory decode side
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDataWrite;
  logic              memWrite;
  logic              memStrobe;
  logic [DATA_W-1:0] memDataRead;

  modport master (
    output cpuReq, cpuWrite, cpuAddr, cpuWdata,
    output dmaReq, dmaWrite, dmaAddr, dmaWdata,
    output memDataRead,
    input  cpuAck, cpuRdata, dmaAck, dmaRdata, dmaFault,
    input  memAddr, memDataWrite, memWrite, memStrobe
  );

  modport slave (
    input  cpuReq, cpuWrite, cpuAddr, cpuWdata,
    input  dmaReq, dmaWrite, dmaAddr, dmaWdata,
    input  memDataRead,
    output cpuAck, cpuRdata, dmaAck, dmaRdata, dmaFault,
    output memAddr, memDataWrite, memWrite, memStrobe
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_grant.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_grant
// Description : CPU-priority grant with a bounded CPU streak so a waiting
//               DMA master is served after at most MAX_CPU_STREAK CPU grants.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_grant
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_CPU_STREAK = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_idle,
  input  logic   i_cpu_req,
  input  logic   i_dma_req,
  output logic   o_grant_valid,
  output owner_t o_grant_owner
);

  localparam int unsigned          c_STREAK_W   = $clog2(MAX_CPU_STREAK + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_CPU_STREAK);

  logic [c_STREAK_W-1:0] r_streak;
  logic                  w_streak_full;

  // Priority decision: CPU first unless DMA has waited out a full streak.
  always_comb begin
    w_streak_full = (r_streak == c_STREAK_MAX);
    o_grant_valid = i_idle && (i_cpu_req || i_dma_req);
    o_grant_owner = OWN_CPU;
    if (i_dma_req && (!i_cpu_req || w_streak_full)) begin
      o_grant_owner = OWN_DMA;
    end
  end

  // Streak counts CPU wins over a waiting DMA; cleared when DMA wins or is absent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_streak <= '0;
    end else if (i_idle) begin
      if (!i_dma_req || (o_grant_owner == OWN_DMA)) begin
        r_streak <= '0;
      end else if (!w_streak_full) begin
        r_streak <= r_streak + c_STREAK_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory bus between CPU and DMA. Each access takes
//               IDLE -> ACCESS (strobe) -> COMPLETE (ack, read data).
//               DMA writes below ROM_TOP are suppressed and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 16,
  parameter int unsigned       DATA_W         = 8,
  parameter int unsigned       MAX_CPU_STREAK = 4,
  parameter logic [ADDR_W-1:0] ROM_TOP        = ADDR_W'(DEFAULT_ROM_TOP)
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_t            r_state;
  owner_t            r_owner;
  logic              r_is_write;
  logic              r_blocked;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_write;
  logic              r_mem_strobe;
  logic              r_cpu_ack;
  logic              r_dma_ack;
  logic              r_dma_fault;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic              w_idle;
  logic              w_grant_valid;
  owner_t            w_grant_owner;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_blocked;

  assign w_idle = (r_state == ST_IDLE);

  mem_arbiter_grant #(
    .MAX_CPU_STREAK (MAX_CPU_STREAK)
  ) u_grant (
    .clk           (clk),
    .reset         (reset),
    .i_idle        (w_idle),
    .i_cpu_req     (bus.cpuReq),
    .i_dma_req     (bus.dmaReq),
    .o_grant_valid (w_grant_valid),
    .o_grant_owner (w_grant_owner)
  );

  // Route the winning port's request fields toward the bus registers.
  always_comb begin
    w_sel_write = bus.cpuWrite;
    w_sel_addr  = bus.cpuAddr;
    w_sel_wdata = bus.cpuWdata;
    if (w_grant_owner == OWN_DMA) begin
      w_sel_write = bus.dmaWrite;
      w_sel_addr  = bus.dmaAddr;
      w_sel_wdata = bus.dmaWdata;
    end
    w_sel_blocked = (w_grant_owner == OWN_DMA) && bus.dmaWrite && (bus.dmaAddr < ROM_TOP);
  end

  // Access sequencer with registered bus drive, acks and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_CPU;
      r_is_write   <= 1'b0;
      r_blocked    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_write  <= 1'b0;
      r_mem_strobe <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
      r_dma_fault  <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_owner      <= w_grant_owner;
            r_is_write   <= w_sel_write;
            r_blocked    <= w_sel_blocked;
            r_mem_addr   <= w_sel_addr;
            r_mem_wdata  <= w_sel_wdata;
            r_mem_write  <= w_sel_write && !w_sel_blocked;
            r_mem_strobe <= 1'b1;
            r_state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_mem_strobe <= 1'b0;
          r_mem_write  <= 1'b0;
          r_cpu_ack    <= (r_owner == OWN_CPU);
          r_dma_ack    <= (r_owner == OWN_DMA);
          r_dma_fault  <= r_blocked;
          r_state      <= ST_COMPLETE;
        end
        ST_COMPLETE: begin
          r_cpu_ack   <= 1'b0;
          r_dma_ack   <= 1'b0;
          r_dma_fault <= 1'b0;
          if (!r_is_write) begin
            if (r_owner == OWN_CPU) begin
              r_cpu_rdata <= bus.memDataRead;
            end else begin
              r_dma_rdata <= bus.memDataRead;
            end
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory data only arrives in the ack cycle, so a read ack forwards it
  // directly; the register takes over from the following cycle.
  assign bus.cpuRdata     = (r_cpu_ack && !r_is_write) ? bus.memDataRead : r_cpu_rdata;
  assign bus.dmaRdata     = (r_dma_ack && !r_is_write) ? bus.memDataRead : r_dma_rdata;
  assign bus.cpuAck       = r_cpu_ack;
  assign bus.dmaAck       = r_dma_ack;
  assign bus.dmaFault     = r_dma_fault;
  assign bus.memAddr      = r_mem_addr;
  assign bus.memDataWrite = r_mem_wdata;
  assign bus.memWrite     = r_mem_write;
  assign bus.memStrobe    = r_mem_strobe;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed scenarios then
//               randomized requests against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned MAX_STREAK = 4;
  localparam logic [15:0] ROM_LIMIT  = 16'h2000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // Model state: CPU-over-waiting-DMA run length and each port's last read data.
  int          m_streak = 0;
  logic [7:0]  m_cpu_rdata = 8'h00;
  logic [7:0]  m_dma_rdata = 8'h00;
  int          consec = 0;
  int          max_consec = 0;
  bit          order[$];

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_arbiter #(
    .ADDR_W         (16),
    .DATA_W         (8),
    .MAX_CPU_STREAK (MAX_STREAK),
    .ROM_TOP        (ROM_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic wr, input logic [15:0] a, input logic [7:0] d);
    bus.cpuReq = 1'b1; bus.cpuWrite = wr; bus.cpuAddr = a; bus.cpuWdata = d;
  endtask

  task automatic set_dma(input logic wr, input logic [15:0] a, input logic [7:0] d);
    bus.dmaReq = 1'b1; bus.dmaWrite = wr; bus.dmaAddr = a; bus.dmaWdata = d;
  endtask

  // One arbitration opportunity, entered at the falling edge of an idle cycle
  // with requests already driven; leaves at the falling edge of the next idle cycle.
  task automatic slot(input logic [7:0] rd);
    bit c, d, win_dma, wr, blocked;
    logic [15:0] a;
    logic [7:0]  wd;
    check("idle_strobe", bus.memStrobe, 1'b0);
    check("idle_memWrite", bus.memWrite, 1'b0);
    check("idle_cpuAck", bus.cpuAck, 1'b0);
    check("idle_dmaAck", bus.dmaAck, 1'b0);
    check("idle_fault", bus.dmaFault, 1'b0);
    c = bus.cpuReq;
    d = bus.dmaReq;
    if (!c && !d) begin
      m_streak = 0;
      consec   = 0;
      @(negedge clk);
      return;
    end
    win_dma = d && (!c || (m_streak == MAX_STREAK));
    if (win_dma || !d) m_streak = 0;
    else if (m_streak < MAX_STREAK) m_streak++;
    if (!win_dma && d) consec++;
    else consec = 0;
    if (consec > max_consec) max_consec = consec;
    order.push_back(win_dma);
    wr      = win_dma ? bus.dmaWrite : bus.cpuWrite;
    a       = win_dma ? bus.dmaAddr  : bus.cpuAddr;
    wd      = win_dma ? bus.dmaWdata : bus.cpuWdata;
    blocked = win_dma && wr && (a < ROM_LIMIT);
    // Strobe cycle
    @(negedge clk);
    check("acc_strobe", bus.memStrobe, 1'b1);
    check("acc_addr", bus.memAddr, a);
    check("acc_memWrite", bus.memWrite, wr && !blocked);
    check("acc_wdata", bus.memDataWrite, wd);
    check("acc_cpuAck", bus.cpuAck, 1'b0);
    check("acc_dmaAck", bus.dmaAck, 1'b0);
    bus.memDataRead = rd;
    // Ack cycle
    @(negedge clk);
    if (!wr) begin
      if (win_dma) m_dma_rdata = rd;
      else m_cpu_rdata = rd;
    end
    check("cmp_strobe", bus.memStrobe, 1'b0);
    check("cmp_memWrite", bus.memWrite, 1'b0);
    check("cmp_addr_held", bus.memAddr, a);
    check("cmp_cpuAck", bus.cpuAck, !win_dma);
    check("cmp_dmaAck", bus.dmaAck, win_dma);
    check("cmp_fault", bus.dmaFault, blocked);
    check("cmp_cpuRdata", bus.cpuRdata, m_cpu_rdata);
    check("cmp_dmaRdata", bus.dmaRdata, m_dma_rdata);
    if (win_dma) bus.dmaReq = 1'b0;
    else bus.cpuReq = 1'b0;
    @(negedge clk);
    bus.memDataRead = 8'($urandom);
    check("held_cpuRdata", bus.cpuRdata, m_cpu_rdata);
    check("held_dmaRdata", bus.dmaRdata, m_dma_rdata);
    check("streak", 32'(dut.u_grant.r_streak), m_streak);
  endtask

  initial begin
    reset = 1'b0;
    bus.cpuReq = 1'b0; bus.cpuWrite = 1'b0; bus.cpuAddr = '0; bus.cpuWdata = '0;
    bus.dmaReq = 1'b0; bus.dmaWrite = 1'b0; bus.dmaAddr = '0; bus.dmaWdata = '0;
    bus.memDataRead = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobe", bus.memStrobe, 1'b0);
    check("rst_memWrite", bus.memWrite, 1'b0);
    check("rst_memAddr", bus.memAddr, 16'h0000);
    check("rst_memData", bus.memDataWrite, 8'h00);
    check("rst_cpuAck", bus.cpuAck, 1'b0);
    check("rst_dmaAck", bus.dmaAck, 1'b0);
    check("rst_fault", bus.dmaFault, 1'b0);
    check("rst_cpuRdata", bus.cpuRdata, 8'h00);
    check("rst_dmaRdata", bus.dmaRdata, 8'h00);
    reset = 1'b1;
    slot(8'h00);

    // CPU read of 0x0005 returning 0xA5
    set_cpu(1'b0, 16'h0005, 8'h00);
    slot(8'hA5);
    check("cpu_read_value", bus.cpuRdata, 8'hA5);
    check("cpu_read_dma_untouched", bus.dmaRdata, 8'h00);

    // Both ports held: CPU wins four times, then DMA
    order.delete();
    max_consec = 0;
    set_cpu(1'b0, 16'h0100, 8'h00);
    set_dma(1'b0, 16'h8000, 8'h00);
    for (int i = 0; i < 10; i++) begin
      slot(8'($urandom));
      if (!bus.cpuReq) set_cpu(1'b0, 16'h0100 + 16'(i), 8'h00);
      if (!bus.dmaReq) set_dma(1'b0, 16'h8000 + 16'(i), 8'h00);
    end
    for (int i = 0; i < 10; i++) check("fair_order", order[i], (i % 5) == 4);
    check("fair_max_streak", max_consec, MAX_STREAK);
    bus.cpuReq = 1'b0;
    bus.dmaReq = 1'b0;
    slot(8'h00);

    // DMA writes around the ROM boundary
    set_dma(1'b1, 16'h1000, 8'h3C); slot(8'h00);
    set_dma(1'b1, 16'h1FFF, 8'h11); slot(8'h00);
    set_dma(1'b1, 16'h2000, 8'h22); slot(8'h00);
    set_dma(1'b1, 16'h4000, 8'h33); slot(8'h00);

    // Reset during the strobe cycle
    set_cpu(1'b0, 16'h0040, 8'h00);
    @(negedge clk);
    check("mid_strobe_pre", bus.memStrobe, 1'b1);
    reset = 1'b0;
    #1;
    m_streak = 0; m_cpu_rdata = 8'h00; m_dma_rdata = 8'h00; consec = 0;
    check("mid_strobe", bus.memStrobe, 1'b0);
    check("mid_memAddr", bus.memAddr, 16'h0000);
    check("mid_cpuRdata", bus.cpuRdata, 8'h00);
    check("mid_dmaRdata", bus.dmaRdata, 8'h00);
    @(negedge clk);
    check("mid_no_ack", bus.cpuAck, 1'b0);
    reset = 1'b1;
    slot(8'h77);
    check("post_reset_read", bus.cpuRdata, 8'h77);

    // DMA only, renewed for three back-to-back accesses
    for (int i = 0; i < 3; i++) begin
      set_dma(1'b0, 16'h4100 + 16'(i * 7), 8'h00);
      slot(8'h50 + 8'(i));
    end

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      if (!bus.cpuReq && ($urandom_range(0, 99) < 55))
        set_cpu(1'($urandom), 16'($urandom), 8'($urandom));
      if (!bus.dmaReq && ($urandom_range(0, 99) < 55))
        set_dma(1'($urandom),
                ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 16'h1FFF))
                                            : 16'($urandom_range(16'h2000, 16'hFFFF)),
                8'($urandom));
      slot(8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
